// File: rtl/wave_pkg.sv
// wave_pkg: shared widths, pipeline latency and palette for the scrolling-wave pixel generator.
package wave_pkg;
    localparam int PIXEL_W   = 12;
    localparam int LUT_DEPTH = 256;
    localparam int LUT_W     = 8;
    localparam int PIPE_LAT  = 3;
    localparam logic [PIXEL_W-1:0] SKY_COLOR   = 12'h006;
    localparam logic [PIXEL_W-1:0] WATER_COLOR = 12'h024;
    localparam logic [PIXEL_W-1:0] WAVE_COLOR  = 12'h0CF;
    localparam logic [PIXEL_W-1:0] GRID_COLOR  = 12'h444;
endpackage

// File: rtl/wave_pixel_gen_sine_lut.sv
// sine_lut: 256-entry signed sine ROM, round(127*sin(2*pi*idx/256)), registered read.
module sine_lut
    import wave_pkg::*;
(
    input  logic                          vclock,
    input  logic                          reset_n,
    input  logic [$clog2(LUT_DEPTH)-1:0]  idx_i,
    output logic signed [LUT_W-1:0]       s_o
);
    // First quarter period only; the other three quadrants are mirrored / negated.
    localparam logic [6:0] QUARTER [65] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,  31,  34,  37,  40,  43,  46,
         49,  51,  54,  57,  60,  63,  65,  68,  71,  73,  76,  78,  81,  83,  85,  88,
         90,  92,  94,  96,  98, 100, 102, 104, 106, 107, 109, 111, 112, 113, 115, 116,
        117, 118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127,
        127
    };
    logic [6:0]       k;
    logic [LUT_W-1:0] s_d, s_q;
    always_comb begin
        k   = idx_i[6] ? 7'd64 - {1'b0, idx_i[5:0]} : {1'b0, idx_i[5:0]};
        s_d = idx_i[7] ? -{1'b0, QUARTER[k]} : {1'b0, QUARTER[k]};
    end
    always_ff @(posedge vclock)
        s_q <= !reset_n ? '0 : s_d;
    assign s_o = s_q;
endmodule

// File: rtl/wave_pixel_gen.sv
// wave_pixel_gen: 3-stage pixel pipeline drawing a scrolling sine wave over sky/water.
// Define WAVE_GRID_EN to overlay a 64-pixel debug grid.
module wave_pixel_gen #(
    parameter int          WAVE_CENTER = 384,
    parameter int          THICK       = 4,
    parameter logic [11:0] WAVE_COLOR  = wave_pkg::WAVE_COLOR,
    parameter logic [11:0] SKY_COLOR   = wave_pkg::SKY_COLOR,
    parameter logic [11:0] WATER_COLOR = wave_pkg::WATER_COLOR
) (
    input  logic        vclock,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [3:0]  speed,
    input  logic        pause,
    output logic [11:0] pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        frame_tick
);
    import wave_pkg::*;

    localparam logic [2:0] SYNC_RST = 3'b001;

    logic [7:0]              phase_q, phase_d, idx_q;
    logic [9:0]              vc1_q, vc2_q;
    logic [2:0]              sync_q [PIPE_LAT];
    logic                    tick_q, rise, grid;
    logic signed [LUT_W-1:0] s;
    logic [10:0]             wave_y;
    logic [11:0]             diff, adiff;
    logic [PIXEL_W-1:0]      pixel_q, pixel_d;
    logic                    unused_hcount;

    assign unused_hcount = ^{hcount[10], hcount[1:0]};

    sine_lut u_lut (
        .vclock  (vclock),
        .reset_n (reset_n),
        .idx_i   (idx_q),
        .s_o     (s)
    );

`ifdef WAVE_GRID_EN
    logic [5:0] hc1_q, hc2_q;
    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            hc1_q <= '0;
            hc2_q <= '0;
        end else begin
            hc1_q <= hcount[5:0];
            hc2_q <= hc1_q;
        end
    end
`endif

    // sync_q[0] doubles as the registered vsync for edge detection.
    always_comb begin
        rise    = vsync & ~sync_q[0][1];
        phase_d = (rise && !pause) ? phase_q + {4'd0, speed} : phase_q;
        wave_y  = 11'(WAVE_CENTER) + {{3{s[LUT_W-1]}}, s};
        diff    = {2'b00, vc2_q} - {wave_y[10], wave_y};
        adiff   = diff[11] ? -diff : diff;
`ifdef WAVE_GRID_EN
        grid    = hc2_q == 6'd0 || vc2_q[5:0] == 6'd0;
`else
        grid    = 1'b0;
`endif
        pixel_d = sync_q[1][0]          ? '0          :
                  adiff < 12'(THICK)    ? WAVE_COLOR  :
                  grid                  ? GRID_COLOR  :
                  diff[11]              ? SKY_COLOR   : WATER_COLOR;
    end

    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            phase_q <= '0;
            idx_q   <= '0;
            vc1_q   <= '0;
            vc2_q   <= '0;
            tick_q  <= 1'b0;
            pixel_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) sync_q[i] <= SYNC_RST;
        end else begin
            phase_q   <= phase_d;
            idx_q     <= hcount[9:2] + phase_q;
            vc1_q     <= vcount;
            vc2_q     <= vc1_q;
            tick_q    <= rise;
            pixel_q   <= pixel_d;
            sync_q[0] <= {hsync, vsync, blank};
            for (int i = 1; i < PIPE_LAT; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pixel                           = pixel_q;
    assign {hsync_out, vsync_out, blank_out} = sync_q[PIPE_LAT-1];
    assign frame_tick                      = tick_q;
endmodule

// File: tb/tb_wave_pixel_gen.sv
// tb_wave_pixel_gen: vector table, corner sequences and random stimulus against a trig-based model.
module tb_wave_pixel_gen;
    logic        vclock = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync = 1'b0, vsync = 1'b0, blank = 1'b1;
    logic [3:0]  speed = '0;
    logic        pause = 1'b0;
    logic [11:0] pixel;
    logic        hsync_out, vsync_out, blank_out, frame_tick;

    always #5 vclock = ~vclock;

    wave_pixel_gen dut (
        .vclock     (vclock),
        .reset_n    (reset_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank),
        .speed      (speed),
        .pause      (pause),
        .pixel      (pixel),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .blank_out  (blank_out),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [11:0] pix;
        logic        hs, vs, bl;
    } exp_t;
    typedef struct {
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        bl;
        logic [11:0] pix;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[14];
    int          total = 0, bad = 0, n_ticks = 0, m_phase = 0, base;
    logic        m_prev_vs = 1'b0;
    logic [11:0] pix_seen;

    function automatic logic [11:0] model_pix(int hc, int vc, logic bl, int ph);
        int  idx, s, wy, d;
        real r;
        idx = ((hc % 1024) / 4 + ph) % 256;
        r   = 127.0 * $sin(2.0 * 3.14159265358979 * idx / 256.0);
        s   = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        wy  = 384 + s;
        d   = vc - wy;
        if (bl) return 12'h000;
        if (d > -4 && d < 4) return 12'h0CF;
        if (vc < wy) return 12'h006;
        return 12'h024;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [10:0] hc, input logic [9:0] vc, input logic hs,
                        input logic vs, input logic bl);
        exp_t e;
        logic et;
        hcount = hc;
        vcount = vc;
        hsync  = hs;
        vsync  = vs;
        blank  = bl;
        et     = 1'b0;
        @(posedge vclock);
        if (reset_n) begin
            q.push_back('{model_pix(int'(hc), int'(vc), bl, m_phase), hs, vs, bl});
            et = vs && !m_prev_vs;
            if (et && !pause) m_phase = (m_phase + int'(speed)) % 256;
            m_prev_vs = vs;
        end
        @(negedge vclock);
        pix_seen = pixel;
        if (frame_tick) n_ticks++;
        if (reset_n) begin
            e = q.pop_front();
            check("tick",  32'(frame_tick), 32'(et));
            check("pixel", 32'(pixel),      32'(e.pix));
            check("hs",    32'(hsync_out),  32'(e.hs));
            check("vs",    32'(vsync_out),  32'(e.vs));
            check("bl",    32'(blank_out),  32'(e.bl));
        end else begin
            check("rst_pix",  32'(pixel),      32'h0);
            check("rst_bl",   32'(blank_out),  32'h1);
            check("rst_hs",   32'(hsync_out),  32'h0);
            check("rst_vs",   32'(vsync_out),  32'h0);
            check("rst_tick", 32'(frame_tick), 32'h0);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (5) tick(11'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        reset_n = 1'b1;
        q.delete();
        repeat (2) q.push_back('{12'h000, 1'b0, 1'b0, 1'b1});
        m_phase   = 0;
        m_prev_vs = 1'b0;
    endtask

    // Vector followed by two blanked fillers: the third sample must be the vector's pixel.
    task automatic apply_check(input string nm, input logic [10:0] hc, input logic [9:0] vc,
                               input logic bl, input logic [11:0] exp);
        tick(hc, vc, 1'b0, 1'b0, bl);
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        check(nm, 32'(pix_seen), 32'(exp));
    endtask

    initial begin
        tbl = '{
            '{11'd0,    10'd384, 1'b0, 12'h0CF},
            '{11'd0,    10'd300, 1'b0, 12'h006},
            '{11'd0,    10'd450, 1'b0, 12'h024},
            '{11'd256,  10'd508, 1'b0, 12'h0CF},
            '{11'd256,  10'd507, 1'b0, 12'h006},
            '{11'd256,  10'd512, 1'b0, 12'h0CF},
            '{11'd256,  10'd515, 1'b0, 12'h024},
            '{11'd512,  10'd380, 1'b0, 12'h006},
            '{11'd512,  10'd387, 1'b0, 12'h0CF},
            '{11'd768,  10'd257, 1'b0, 12'h0CF},
            '{11'd768,  10'd253, 1'b0, 12'h006},
            '{11'd768,  10'd261, 1'b0, 12'h024},
            '{11'd0,    10'd384, 1'b1, 12'h000},
            '{11'd1280, 10'd511, 1'b0, 12'h0CF}
        };
        do_reset();
        for (int i = 0; i < 14; i++)
            apply_check($sformatf("tbl%0d", i), tbl[i].hc, tbl[i].vc, tbl[i].bl, tbl[i].pix);

        speed = 4'd3;
        base  = n_ticks;
        repeat (86) begin
            tick('0, '0, 1'b0, 1'b1, 1'b1);
            tick('0, '0, 1'b0, 1'b0, 1'b1);
        end
        check("ticks86", 32'(n_ticks - base), 32'd86);
        apply_check("wrap_wave", 11'd248, 10'd508, 1'b0, 12'h0CF);
        apply_check("wrap_sky",  11'd248, 10'd507, 1'b0, 12'h006);

        pause = 1'b1;
        base  = n_ticks;
        repeat (10) begin
            tick('0, '0, 1'b0, 1'b1, 1'b1);
            tick('0, '0, 1'b0, 1'b0, 1'b1);
        end
        check("ticks10", 32'(n_ticks - base), 32'd10);
        apply_check("paused", 11'd0, 10'd390, 1'b0, 12'h0CF);
        pause = 1'b0;
        tick('0, '0, 1'b0, 1'b1, 1'b1);
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        apply_check("resume_sky",  11'd0, 10'd390, 1'b0, 12'h006);
        apply_check("resume_wave", 11'd0, 10'd400, 1'b0, 12'h0CF);

        repeat (300) begin
            speed = 4'($urandom);
            pause = ($urandom_range(3) == 0);
            tick(11'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        do_reset();
        repeat (100) begin
            speed = 4'($urandom);
            pause = ($urandom_range(3) == 0);
            tick(11'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
